// File: rtl/fshare_pkg.sv
// Shared types and default widths for the ping-pong frame buffer.
package fshare_pkg;

    // Control FSM encoding.
    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } fshare_state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/fshare_bank_ram.sv
// One frame bank: single write port plus two registered read ports (block-RAM friendly).
module fshare_bank_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read ports (read-first on collision with the write port).
    always_ff @(posedge clk) begin
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/frame_share_pingpong.sv
// Host/client ping-pong frame buffer with commit/release swap handshake.
// Optional overrun counter enabled by defining FSHARE_OVERRUN_CNT_EN.
module frame_share_pingpong
    import fshare_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    input  logic              host_commit,
    input  logic [ADDR_W:0]   host_len,
    output logic              host_busy,
    input  logic [ADDR_W-1:0] client_addr,
    output logic [DATA_W-1:0] client_dout,
    input  logic              client_release,
    output logic [ADDR_W:0]   client_len,
    output logic              client_irq,
`ifdef FSHARE_OVERRUN_CNT_EN
    output logic [CNT_W-1:0]  overrun_cnt,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    fshare_state_e     state_q, state_d;
    logic              front_sel_q;
    logic              rd_front_q;
    logic              waiting_q;
    logic [ADDR_W:0]   pending_len_q;
    logic [ADDR_W:0]   client_len_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic              swap;
    logic              commit_take;
    logic              we_take;
    logic [ADDR_W:0]   len_sat;
    logic [DATA_W-1:0] b0_host, b0_client, b1_host, b1_client;

    // Next state, handshake decode and write qualification.
    always_comb begin
        state_d     = state_q;
        host_busy   = (state_q != ST_FILL);
        client_irq  = (state_q == ST_SWAP);
        swap        = (state_q == ST_SWAP);
        commit_take = (state_q == ST_FILL) && host_commit;
        we_take     = host_we && !host_busy;
        len_sat     = (host_len > FULL_LEN) ? FULL_LEN : host_len;
        unique case (state_q)
            ST_FILL:    if (host_commit) state_d = ST_PENDING;
            ST_PENDING: if (waiting_q || client_release) state_d = ST_SWAP;
            ST_SWAP:    state_d = ST_FILL;
            default:    state_d = ST_FILL;
        endcase
    end

    // Control registers: FSM, bank select, lengths, swap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FILL;
            front_sel_q   <= 1'b0;
            rd_front_q    <= 1'b0;
            waiting_q     <= 1'b0;
            pending_len_q <= '0;
            client_len_q  <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_front_q <= front_sel_q;
            if (commit_take) begin
                pending_len_q <= len_sat;
            end
            // A release during the swap cycle is kept for the next frame.
            if (client_release) begin
                waiting_q <= 1'b1;
            end else if (swap) begin
                waiting_q <= 1'b0;
            end
            if (swap) begin
                front_sel_q  <= ~front_sel_q;
                client_len_q <= pending_len_q;
                frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef FSHARE_OVERRUN_CNT_EN
    logic [CNT_W-1:0] overrun_q;

    // Count cycles with a rejected commit and/or write; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else if ((host_commit || host_we) && host_busy && !(&overrun_q)) begin
            overrun_q <= overrun_q + CNT_W'(1);
        end
    end

    assign overrun_cnt = overrun_q;
`endif

    // Back bank is bank0 when front_sel=1, bank1 when front_sel=0.
    fshare_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .we      (we_take && front_sel_q),
        .waddr   (host_addr),
        .wdata   (host_din),
        .raddr_a (host_addr),
        .rdata_a (b0_host),
        .raddr_b (client_addr),
        .rdata_b (b0_client)
    );

    fshare_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .we      (we_take && !front_sel_q),
        .waddr   (host_addr),
        .wdata   (host_din),
        .raddr_a (host_addr),
        .rdata_a (b1_host),
        .raddr_b (client_addr),
        .rdata_b (b1_client)
    );

    assign host_dout   = rd_front_q ? b0_host : b1_host;
    assign client_dout = rd_front_q ? b1_client : b0_client;
    assign client_len  = client_len_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
